softmax_seq_ctrl: RTL and testbench

- Synthesizable run sequencer for softmax_core.
- Loads a row stream into the core BRAM through port A, pulses start, and waits for busy to rise and then fall, with timeouts.
- Reads results back through port B with a pipelined, parametrised read latency and compares each row against a golden stream.
- Replaces the fixed 12-row, exact-match, non-pipelined bench flow with a reusable block for FPGA self-test and bench-driven regression.

---
 rtl/softmax_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_softmax_seq_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_seq_ctrl.sv
// softmax_seq_ctrl: loads rows into softmax_core BRAM, runs the core, reads results back and checks them against a golden stream.
// Define SOFTMAX_SEQ_TOL_EN to compare per LANE_W lane within TOL LSB instead of an exact row match.
module softmax_seq_ctrl #(
  parameter int DATA_W   = 1028,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 12,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 12,
  parameter int RD_LAT   = 2,
  parameter int START_W  = 2,
  parameter int TIMEOUT  = 65535,
  parameter int LANE_W   = 16,
  parameter int TOL      = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_go,
  output logic                       o_done,
  output logic                       o_pass,
  output logic [1:0]                 o_err_code,
  output logic [$clog2(DEPTH+1)-1:0] o_err_cnt,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [DATA_W-1:0]          i_in_data,
  input  logic                       i_gold_valid,
  output logic                       o_gold_ready,
  input  logic [DATA_W-1:0]          i_gold_data,
  output logic                       o_core_start,
  input  logic                       i_core_busy,
  output logic                       o_cena,
  output logic                       o_wea,
  output logic [ADDR_W-1:0]          o_addra,
  output logic [DATA_W-1:0]          o_dina,
  output logic                       o_cenb,
  output logic [ADDR_W-1:0]          o_addrb,
  input  logic [DATA_W-1:0]          i_doutb,
  output logic                       o_res_valid,
  output logic [ADDR_W-1:0]          o_res_idx,
  output logic [DATA_W-1:0]          o_res_data,
  output logic                       o_res_miss
);
  localparam int CW   = $clog2(DEPTH+1);
  localparam int TMAX = (TIMEOUT > START_W) ? TIMEOUT : START_W;
  localparam int TW   = $clog2(TMAX+1);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_HI, S_WAIT_LO, S_READ, S_DRAIN, S_DONE
  } state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [CW-1:0]     err_cnt_q, err_cnt_d;
  logic [RD_LAT-1:0] pv_q, pv_d;
  logic [ADDR_W-1:0] pidx_q [RD_LAT];
  logic [ADDR_W-1:0] pidx_d [RD_LAT];
  logic [DATA_W-1:0] pgold_q [RD_LAT];
  logic [DATA_W-1:0] pgold_d [RD_LAT];
  logic              res_valid_q, res_valid_d;
  logic [ADDR_W-1:0] res_idx_q, res_idx_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_miss_q, res_miss_d;
  logic              beat, issue, last, miss, cmp;
  assign beat  = (state_q == S_LOAD) && i_in_valid;
  assign issue = (state_q == S_READ) && i_gold_valid;
  assign last  = cnt_q == CW'(DEPTH-1);
  assign cmp   = pv_q[RD_LAT-1];
`ifdef SOFTMAX_SEQ_TOL_EN
  localparam int NL = DATA_W / LANE_W;
  logic [LANE_W-1:0] la, lb;
  always_comb begin
    miss = (i_doutb >> (NL*LANE_W)) != (pgold_q[RD_LAT-1] >> (NL*LANE_W));
    la = '0;
    lb = '0;
    for (int i = 0; i < NL; i++) begin
      la = i_doutb[i*LANE_W +: LANE_W];
      lb = pgold_q[RD_LAT-1][i*LANE_W +: LANE_W];
      if (((la > lb) ? la - lb : lb - la) > LANE_W'(TOL)) miss = 1'b1;
    end
  end
`else
  assign miss = i_doutb != pgold_q[RD_LAT-1];
`endif
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    err_code_d = err_code_q;
    err_cnt_d  = (cmp && miss && err_cnt_q != CW'(DEPTH)) ? err_cnt_q + 1'b1 : err_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: if (i_go) begin
        state_d    = S_LOAD;
        cnt_d      = '0;
        tmr_d      = '0;
        err_code_d = '0;
        err_cnt_d  = '0;
      end
      S_LOAD: if (beat) begin
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        tmr_d   = '0;
        state_d = last ? S_START : S_LOAD;
      end
      S_START: begin
        tmr_d   = (tmr_q == TW'(START_W-1)) ? '0 : tmr_q + 1'b1;
        state_d = (tmr_q == TW'(START_W-1)) ? S_WAIT_HI : S_START;
      end
      S_WAIT_HI: if (i_core_busy) begin
        state_d = S_WAIT_LO;
        tmr_d   = '0;
      end else if (tmr_q == TW'(TIMEOUT)) begin
        state_d    = S_DONE;
        err_code_d = 2'd1;
      end else tmr_d = tmr_q + 1'b1;
      S_WAIT_LO: if (!i_core_busy) begin
        state_d = S_READ;
        cnt_d   = '0;
      end else if (tmr_q == TW'(TIMEOUT)) begin
        state_d    = S_DONE;
        err_code_d = 2'd2;
      end else tmr_d = tmr_q + 1'b1;
      S_READ: if (issue) begin
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        state_d = last ? S_DRAIN : S_READ;
      end
      S_DRAIN: state_d = (pv_q == '0) ? S_DONE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end
  // Stage RD_LAT-1 lines up with i_doutb for the read issued RD_LAT cycles earlier.
  always_comb begin
    pv_d       = (pv_q << 1) | RD_LAT'(issue);
    pidx_d[0]  = ADDR_W'(cnt_q);
    pgold_d[0] = i_gold_data;
    for (int i = 1; i < RD_LAT; i++) begin
      pidx_d[i]  = pidx_q[i-1];
      pgold_d[i] = pgold_q[i-1];
    end
    res_valid_d = cmp;
    res_idx_d   = cmp ? pidx_q[RD_LAT-1] : res_idx_q;
    res_data_d  = cmp ? i_doutb : res_data_q;
    res_miss_d  = cmp && miss;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tmr_q       <= '0;
      err_code_q  <= '0;
      err_cnt_q   <= '0;
      pv_q        <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
      res_miss_q  <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        pidx_q[i]  <= '0;
        pgold_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      err_code_q  <= err_code_d;
      err_cnt_q   <= err_cnt_d;
      pv_q        <= pv_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_data_q  <= res_data_d;
      res_miss_q  <= res_miss_d;
      for (int i = 0; i < RD_LAT; i++) begin
        pidx_q[i]  <= pidx_d[i];
        pgold_q[i] <= pgold_d[i];
      end
    end
  end
  assign o_in_ready   = state_q == S_LOAD;
  assign o_gold_ready = state_q == S_READ;
  assign o_cena       = beat;
  assign o_wea        = beat;
  assign o_addra      = beat ? ADDR_W'(IN_BASE) + ADDR_W'(cnt_q) : '0;
  assign o_dina       = beat ? i_in_data : '0;
  assign o_cenb       = issue;
  assign o_addrb      = issue ? ADDR_W'(OUT_BASE) + ADDR_W'(cnt_q) : '0;
  assign o_core_start = state_q == S_START;
  assign o_done       = state_q == S_DONE;
  assign o_pass       = o_done && err_cnt_q == '0 && err_code_q == 2'd0;
  assign o_err_code   = err_code_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_res_valid  = res_valid_q;
  assign o_res_idx    = res_idx_q;
  assign o_res_data   = res_data_q;
  assign o_res_miss   = res_miss_q;
endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// tb_softmax_seq_ctrl: directed runs of softmax_seq_ctrl against a BRAM/core model with a result scoreboard.
module tb_softmax_seq_ctrl;
  localparam int DW = 1028, AW = 5, DEPTH = 12, IB = 0, OB = 12, RDL = 2, SW = 2, TO = 100;
  localparam int EW = $clog2(DEPTH+1);
  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    bit            miss;
  } exp_t;
  logic clk = 1'b0, i_rst_n, i_go, i_in_valid, i_gold_valid, i_core_busy;
  logic [DW-1:0] i_in_data, i_gold_data, doutb;
  logic o_done, o_pass, o_in_ready, o_gold_ready, o_core_start, o_cena, o_wea, o_cenb;
  logic o_res_valid, o_res_miss;
  logic [1:0] o_err_code;
  logic [EW-1:0] o_err_cnt;
  logic [AW-1:0] o_addra, o_addrb, o_res_idx;
  logic [DW-1:0] o_dina, o_res_data;
  logic [DW-1:0] mem [32];
  logic [DW-1:0] rd [RDL];
  logic xform = 1'b0;
  bit busy_en = 1'b0, tol_mode = 1'b0;
  int checks = 0, errors = 0;
  int wr_n = 0, wr_base = 0, start_cyc = 0, res_n = 0, cenb_n = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  softmax_seq_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .IN_BASE(IB), .OUT_BASE(OB),
    .RD_LAT(RDL), .START_W(SW), .TIMEOUT(TO), .LANE_W(16), .TOL(1)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_go(i_go), .o_done(o_done), .o_pass(o_pass),
    .o_err_code(o_err_code), .o_err_cnt(o_err_cnt),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .i_gold_valid(i_gold_valid), .o_gold_ready(o_gold_ready), .i_gold_data(i_gold_data),
    .o_core_start(o_core_start), .i_core_busy(i_core_busy),
    .o_cena(o_cena), .o_wea(o_wea), .o_addra(o_addra), .o_dina(o_dina),
    .o_cenb(o_cenb), .o_addrb(o_addrb), .i_doutb(doutb),
    .o_res_valid(o_res_valid), .o_res_idx(o_res_idx), .o_res_data(o_res_data), .o_res_miss(o_res_miss));
  function automatic logic [DW-1:0] in_row(input int k);
    logic [DW-1:0] r = '0;
    for (int j = 0; j < DW/16; j++) r[j*16 +: 16] = 16'(k*257 + j);
    r[DW-1 -: 4] = 4'(k);
    return r;
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk(nm, 64'({o_done, o_pass, o_err_code, o_err_cnt, o_in_ready, o_gold_ready, o_core_start,
      o_cena, o_wea, o_addra, o_cenb, o_addrb, o_res_valid, o_res_idx, o_res_miss,
      |o_dina, |o_res_data}), 64'd0);
  endtask
  always @(posedge clk) begin
    if (o_cena && o_wea) mem[o_addra] <= o_dina;
    if (xform) for (int k = 0; k < DEPTH; k++) mem[OB+k] <= ~mem[IB+k];
    rd[0] <= o_cenb ? mem[o_addrb] : '0;
    for (int i = 1; i < RDL; i++) rd[i] <= rd[i-1];
  end
  assign doutb = rd[RDL-1];
  initial begin
    i_core_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (o_core_start && busy_en) begin
        repeat (3) @(negedge clk);
        i_core_busy = 1'b1;
        repeat (40) @(negedge clk);
        xform = 1'b1;
        @(negedge clk);
        xform = 1'b0;
        i_core_busy = 1'b0;
      end
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_cena) begin
        chk("wr_we", 64'(o_wea), 64'd1);
        chk("wr_addr", 64'(o_addra), 64'((IB + wr_n - wr_base) % 32));
        chk("wr_data", 64'(o_dina == in_row(wr_n - wr_base)), 64'd1);
        wr_n++;
      end
      if (o_core_start) start_cyc++;
      if (o_cenb) cenb_n++;
      if (o_res_valid) begin
        res_n++;
        if (q.size() == 0) chk("res_unexpected", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("res_idx", 64'(o_res_idx), 64'(e.idx));
          chk("res_data", 64'(o_res_data == e.data), 64'd1);
          chk("res_miss", 64'(o_res_miss), 64'(e.miss));
        end
      end
    end
  end
  task automatic feed_in(input bit gap);
    int n;
    for (int k = 0; k < DEPTH; k++) begin
      if (gap) begin
        i_in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      i_in_valid = 1'b1;
      i_in_data = in_row(k);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!o_in_ready && n < 500);
      if (!o_in_ready) begin
        chk("in_ready_wait", 64'(o_in_ready), 64'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    i_in_valid = 1'b0;
  endtask
  task automatic feed_gold(input bit gap, input int flip, input int rst_row);
    int n;
    exp_t e;
    logic [DW-1:0] g;
    for (int k = 0; k < DEPTH; k++) begin
      if (gap) begin
        i_gold_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      g = ~in_row(k);
      if (k == flip) g[17] = ~g[17];
      if (tol_mode && k == 2) g[15:0] = g[15:0] + 16'd1;
      if (tol_mode && k == 7) g[63:48] = g[63:48] + 16'd2;
      i_gold_valid = 1'b1;
      i_gold_data = g;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!o_gold_ready && n < 2000);
      if (!o_gold_ready) begin
        chk("gold_ready_wait", 64'(o_gold_ready), 64'd1);
        break;
      end
      e.idx = k;
      e.data = ~in_row(k);
      e.miss = (k == flip) || (tol_mode && k == 7);
      q.push_back(e);
      @(posedge clk);
      #1;
      if (k == rst_row) begin
        i_rst_n = 1'b0;
        #1;
        chk_zero("async_reset_mid_read");
        break;
      end
    end
    i_gold_valid = 1'b0;
  endtask
  task automatic run(input bit gap, input int flip, input int rst_row, input bit busy);
    int n, s0, r0, c0, exp_err;
    busy_en = busy;
    wr_base = wr_n;
    s0 = start_cyc;
    r0 = res_n;
    c0 = cenb_n;
    exp_err = (flip >= 0 ? 1 : 0) + (tol_mode ? 1 : 0);
    @(posedge clk);
    #1 i_go = 1'b1;
    @(posedge clk);
    #1 i_go = 1'b0;
    if (busy) fork
      feed_in(gap);
      feed_gold(gap, flip, rst_row);
    join
    else feed_in(gap);
    if (rst_row >= 0) begin
      q.delete();
      repeat (3) @(posedge clk);
      #1 i_rst_n = 1'b1;
      return;
    end
    if (!busy) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (o_core_start && n < 20);
    end
    n = 0;
    while (!o_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("done", 64'(o_done), 64'd1);
    if (!busy) chk($sformatf("rise_timeout_cycles_%0d", n), 64'(n >= 100 && n <= 102), 64'd1);
    chk("err_code", 64'(o_err_code), busy ? 64'd0 : 64'd1);
    chk("err_cnt", 64'(o_err_cnt), busy ? 64'(exp_err) : 64'd0);
    chk("pass", 64'(o_pass), 64'(busy && exp_err == 0));
    chk("writes", 64'(wr_n - wr_base), 64'(DEPTH));
    chk("start_cycles", 64'(start_cyc - s0), 64'(SW));
    chk("strobes", 64'(res_n - r0), busy ? 64'(DEPTH) : 64'd0);
    chk("reads", 64'(cenb_n - c0), busy ? 64'(DEPTH) : 64'd0);
    chk("sb_empty", 64'(q.size()), 64'd0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    i_rst_n = 1'b0;
    i_go = 1'b0;
    i_in_valid = 1'b0;
    i_gold_valid = 1'b0;
    i_in_data = '0;
    i_gold_data = '0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset_outputs");
    i_rst_n = 1'b1;
    run(1'b0, -1, -1, 1'b1);
    run(1'b0, 5, -1, 1'b1);
    run(1'b0, -1, -1, 1'b0);
    run(1'b1, -1, -1, 1'b1);
    run(1'b0, -1, 6, 1'b1);
    run(1'b0, -1, -1, 1'b1);
`ifdef SOFTMAX_SEQ_TOL_EN
    tol_mode = 1'b1;
    run(1'b0, -1, -1, 1'b1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
